// File: rtl/int8_sched_pkg.sv
// rtl/int8_sched_pkg.sv - shared types and constants for the INT8 tile scheduler
package int8_sched_pkg;

    localparam int NUM_BANKS             = 2;
    localparam int SCHED_PSU_DEPTH_WIDTH = 9;
    localparam int SCHED_TILE_CNT_WIDTH  = 8;
    localparam int SCHED_K_CNT_WIDTH     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUF,
        ST_START,
        ST_RUN,
        ST_FINISH
    } sched_state_e;

    typedef struct packed {
        logic [SCHED_TILE_CNT_WIDTH-1:0]  num_tiles;
        logic [SCHED_K_CNT_WIDTH-1:0]     k_steps;
        logic [SCHED_PSU_DEPTH_WIDTH-1:0] psu_depth;
    } sched_job_t;

endpackage

// File: rtl/int8_bank_scoreboard.sv
// rtl/int8_bank_scoreboard.sv - full/empty tracking of the ping-pong input banks
module int8_bank_scoreboard
    import int8_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic                 set_bank,
    input  logic                 clr_en,
    input  logic                 clr_bank,
    output logic [NUM_BANKS-1:0] full,
    output logic                 err_overflow
);

    logic [NUM_BANKS-1:0] set_vec;
    logic [NUM_BANKS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_bank] = 1'b1;
        if (clr_en) clr_vec[clr_bank] = 1'b1;
    end

    // Set is applied after clear so a refill in the release cycle is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full         <= '0;
            err_overflow <= 1'b0;
        end else begin
            full <= (full & ~clr_vec) | set_vec;
            if (set_en && full[set_bank]) err_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/int8_tile_sched.sv
// rtl/int8_tile_sched.sv - GEMM job scheduler feeding the INT8 exec controller
// Optional stall counter enabled by defining INT8_SCHED_PERF_EN.
module int8_tile_sched
    import int8_sched_pkg::*;
#(
    parameter int PSU_DEPTH_WIDTH = SCHED_PSU_DEPTH_WIDTH,
    parameter int TILE_CNT_WIDTH  = SCHED_TILE_CNT_WIDTH,
    parameter int K_CNT_WIDTH     = SCHED_K_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [TILE_CNT_WIDTH-1:0]  job_num_tiles,
    input  logic [K_CNT_WIDTH-1:0]     job_k_steps,
    input  logic [PSU_DEPTH_WIDTH-1:0] job_psu_depth,
    input  logic                       load_done,
    input  logic                       load_bank,
    output logic                       bank_release,
    output logic                       release_bank,
    output logic                       exec_start,
    input  logic                       exec_done,
    output logic                       psu_acc_en,
    output logic [PSU_DEPTH_WIDTH-1:0] psu_depth,
    output logic                       exec_bank,
    output logic [TILE_CNT_WIDTH-1:0]  tile_idx,
    output logic [K_CNT_WIDTH-1:0]     k_idx,
    output logic                       busy,
    output logic                       job_done,
    output logic                       err_overflow,
    output logic [31:0]                perf_stall_cycles
);

    localparam logic [TILE_CNT_WIDTH-1:0] TILE_ONE = 1;
    localparam logic [K_CNT_WIDTH-1:0]    K_ONE    = 1;

    sched_state_e         state;
    sched_job_t           job;
    logic [NUM_BANKS-1:0] full;
    logic                 pass_done;
    logic                 last_k;
    logic                 last_tile;
    logic                 job_empty;

    assign pass_done = (state == ST_RUN) && exec_done;
    assign last_k    = (k_idx == job.k_steps - K_ONE);
    assign last_tile = (tile_idx == job.num_tiles - TILE_ONE);
    assign job_empty = (job.num_tiles == '0) || (job.k_steps == '0);

    int8_bank_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_en       (load_done),
        .set_bank     (load_bank),
        .clr_en       (pass_done),
        .clr_bank     (exec_bank),
        .full         (full),
        .err_overflow (err_overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            job          <= '0;
            job_ready    <= 1'b1;
            busy         <= 1'b0;
            exec_start   <= 1'b0;
            job_done     <= 1'b0;
            bank_release <= 1'b0;
            release_bank <= 1'b0;
            psu_acc_en   <= 1'b0;
            psu_depth    <= '0;
            exec_bank    <= 1'b0;
            tile_idx     <= '0;
            k_idx        <= '0;
        end else begin
            exec_start   <= 1'b0;
            job_done     <= 1'b0;
            bank_release <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        job.num_tiles <= job_num_tiles;
                        job.k_steps   <= job_k_steps;
                        job.psu_depth <= job_psu_depth;
                        tile_idx      <= '0;
                        k_idx         <= '0;
                        exec_bank     <= 1'b0;
                        job_ready     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_WAIT_BUF;
                    end
                end
                // Empty jobs are screened here on the latched descriptor, so they
                // finish without ever touching the banks.
                ST_WAIT_BUF: begin
                    if (job_empty) begin
                        job_done <= 1'b1;
                        state    <= ST_FINISH;
                    end else if (full[exec_bank]) begin
                        exec_start <= 1'b1;
                        psu_acc_en <= last_k;
                        psu_depth  <= job.psu_depth;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (exec_done) begin
                        bank_release <= 1'b1;
                        release_bank <= exec_bank;
                        exec_bank    <= ~exec_bank;
                        if (last_k) begin
                            k_idx    <= '0;
                            tile_idx <= tile_idx + TILE_ONE;
                        end else begin
                            k_idx <= k_idx + K_ONE;
                        end
                        if (last_k && last_tile) begin
                            job_done <= 1'b1;
                            state    <= ST_FINISH;
                        end else begin
                            state <= ST_WAIT_BUF;
                        end
                    end
                end
                ST_FINISH: begin
                    exec_bank <= 1'b0;
                    job_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INT8_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
        end else if (state == ST_WAIT_BUF && perf_stall_cycles != '1) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_int8_tile_sched.sv
// tb/tb_int8_tile_sched.sv - directed self-checking bench for int8_tile_sched
module tb_int8_tile_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_num_tiles;
    logic [5:0]  job_k_steps;
    logic [8:0]  job_psu_depth;
    logic        load_done;
    logic        load_bank;
    logic        bank_release;
    logic        release_bank;
    logic        exec_start;
    logic        exec_done;
    logic        psu_acc_en;
    logic [8:0]  psu_depth;
    logic        exec_bank;
    logic [7:0]  tile_idx;
    logic [5:0]  k_idx;
    logic        busy;
    logic        job_done;
    logic        err_overflow;
    logic [31:0] perf_stall_cycles;

    int total = 0;
    int bad   = 0;

    int8_tile_sched dut (
        .clk               (clk),
        .rst               (rst),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_num_tiles     (job_num_tiles),
        .job_k_steps       (job_k_steps),
        .job_psu_depth     (job_psu_depth),
        .load_done         (load_done),
        .load_bank         (load_bank),
        .bank_release      (bank_release),
        .release_bank      (release_bank),
        .exec_start        (exec_start),
        .exec_done         (exec_done),
        .psu_acc_en        (psu_acc_en),
        .psu_depth         (psu_depth),
        .exec_bank         (exec_bank),
        .tile_idx          (tile_idx),
        .k_idx             (k_idx),
        .busy              (busy),
        .job_done          (job_done),
        .err_overflow      (err_overflow),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic b);
        load_done = 1'b1;
        load_bank = b;
        step();
        load_done = 1'b0;
    endtask

    task automatic accept(input logic [7:0] t, input logic [5:0] k, input logic [8:0] d);
        job_valid     = 1'b1;
        job_num_tiles = t;
        job_k_steps   = k;
        job_psu_depth = d;
        step();
        job_valid = 1'b0;
    endtask

    // Called in a START cycle: one RUN cycle, then exec_done; returns at D+1.
    task automatic finish_pass();
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int dcnt, lc0, lc1, nstart, nrel, ndone, after;
    int sb[6], sa[6], sk[6], st[6], sd[6];
    logic [31:0] perf_exp;

    initial begin
        rst = 1'b1; job_valid = 1'b0; job_num_tiles = '0; job_k_steps = '0;
        job_psu_depth = '0; load_done = 1'b0; load_bank = 1'b0; exec_done = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_job_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_exec_start", exec_start, 0);
        check("rst_job_done", job_done, 0);
        check("rst_bank_release", bank_release, 0);
        check("rst_err", err_overflow, 0);
        check("rst_perf", perf_stall_cycles, 0);
        check("rst_exec_bank", exec_bank, 0);
        check("rst_psu_depth", psu_depth, 0);

        // 20 cycles stalled in WAIT_BUF: load arrives 19 cycles after accept
        accept(8'd1, 6'd1, 9'd5);
        repeat (18) step();
        load(1'b0);
        step();
        check("stall_start_l2", exec_start, 1);
        finish_pass();
        check("stall_job_done", job_done, 1);
        step();
`ifdef INT8_SCHED_PERF_EN
        perf_exp = 32'd20;
`else
        perf_exp = 32'd0;
`endif
        check("perf_stall", perf_stall_cycles, perf_exp);

        // single pass job with bank0 preloaded
        load(1'b0);
        accept(8'd1, 6'd1, 9'd16);
        check("t1_busy", busy, 1);
        check("t1_ready_low", job_ready, 0);
        check("t1_no_start_t1", exec_start, 0);
        step();
        check("t1_start_t2", exec_start, 1);
        check("t1_acc_en", psu_acc_en, 1);
        check("t1_depth", psu_depth, 16);
        check("t1_bank", exec_bank, 0);
        step();
        check("t1_start_pulse", exec_start, 0);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("t1_release", bank_release, 1);
        check("t1_release_bank", release_bank, 0);
        check("t1_job_done", job_done, 1);
        check("t1_ready_d1", job_ready, 0);
        step();
        check("t1_ready_d2", job_ready, 1);
        check("t1_done_pulse", job_done, 0);
        check("t1_release_pulse", bank_release, 0);
        check("t1_idle", busy, 0);

        // empty job: tiles == 0
        accept(8'd0, 6'd3, 9'd8);
        check("zero_done_t1", job_done, 0);
        step();
        check("zero_done_t2", job_done, 1);
        check("zero_no_start", exec_start, 0);
        check("zero_no_release", bank_release, 0);
        step();
        check("zero_ready", job_ready, 1);

        // 2 tiles x 3 K-steps, DMA refills 5 cycles after each release
        load(1'b0);
        load(1'b1);
        accept(8'd2, 6'd3, 9'd33);
        for (int i = 0; i < 6; i++) begin
            sb[i] = 99; sa[i] = 99; sk[i] = 99; st[i] = 99; sd[i] = 99;
        end
        dcnt = 0; lc0 = 0; lc1 = 0; nstart = 0; nrel = 0; ndone = 0; after = 0;
        for (int cyc = 0; cyc < 400 && after < 12; cyc++) begin
            if (exec_start) begin
                if (nstart < 6) begin
                    sb[nstart] = int'(exec_bank);
                    sa[nstart] = int'(psu_acc_en);
                    sk[nstart] = int'(k_idx);
                    st[nstart] = int'(tile_idx);
                    sd[nstart] = int'(psu_depth);
                end
                nstart++;
                dcnt = 2;
            end else if (dcnt > 0) begin
                dcnt--;
            end
            exec_done = (dcnt == 1);
            load_done = 1'b0;
            if (lc0 > 0) begin
                lc0--;
                if (lc0 == 0) begin load_done = 1'b1; load_bank = 1'b0; end
            end
            if (lc1 > 0) begin
                lc1--;
                if (lc1 == 0) begin load_done = 1'b1; load_bank = 1'b1; end
            end
            if (bank_release) begin
                nrel++;
                if (release_bank) lc1 = 5; else lc0 = 5;
            end
            if (job_done) ndone++;
            if (ndone > 0) after++;
            step();
        end
        exec_done = 1'b0;
        load_done = 1'b0;
        check("multi_job_done", ndone, 1);
        check("multi_starts", nstart, 6);
        check("multi_releases", nrel, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("multi_bank_%0d", i), sb[i], i % 2);
            check($sformatf("multi_acc_%0d", i), sa[i], (i % 3 == 2) ? 1 : 0);
            check($sformatf("multi_k_%0d", i), sk[i], i % 3);
            check($sformatf("multi_tile_%0d", i), st[i], i / 3);
            check($sformatf("multi_depth_%0d", i), sd[i], 33);
        end
        check("multi_no_err", err_overflow, 0);

        // async reset in RUN, then a stray exec_done
        accept(8'd1, 6'd2, 9'd9);
        step();
        check("rst_run_start", exec_start, 1);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_ready", job_ready, 1);
        check("async_depth", psu_depth, 0);
        step();
        rst = 1'b0;
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("stray_release", bank_release, 0);
        check("stray_job_done", job_done, 0);
        check("stray_start", exec_start, 0);
        check("stray_busy", busy, 0);
        check("stray_ready", job_ready, 1);
        check("stray_perf", perf_stall_cycles, 0);

        // double load of bank1 from an empty scoreboard
        load(1'b1);
        check("ovf_first_load", err_overflow, 0);
        load(1'b1);
        check("ovf_second_load", err_overflow, 1);
        load(1'b0);
        accept(8'd1, 6'd1, 9'd7);
        step();
        check("ovf_still_runs", exec_start, 1);
        finish_pass();
        check("ovf_job_done", job_done, 1);
        check("ovf_sticky", err_overflow, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
